// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC selection, redirect flush sequencing and EPC capture
// Optional macro PC_MISALIGN_TRAP_EN: trap misaligned jump/branch targets and add misalign_o.
module pc_sequencer #(
    parameter int           N            = 32,
    parameter logic [N-1:0] RESET_PC     = 32'h00400000,
    parameter logic [N-1:0] EXC_VECTOR   = 32'h80000180,
    parameter int           FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] pc_value,
    input  logic         stall_i,
    input  logic         jump_i,
    input  logic [N-1:0] jump_target_i,
    input  logic         branch_taken_i,
    input  logic [N-1:0] branch_target_i,
    input  logic         exc_i,
    input  logic [N-1:0] exc_pc_i,
    output logic [N-1:0] new_pc,
    output logic         flush_ifid,
    output logic         flush_idex,
    output logic [N-1:0] epc,
    output logic [1:0]   state
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic         misalign_o
`endif
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        EXC   = 2'd3
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    state_t       cur_state, nxt_state;
    logic [2:0]   flush_cnt, nxt_cnt;
    logic [N-1:0] nxt_epc;
    logic [N-1:0] seq_pc;
    logic [N-1:0] br_tgt, jp_tgt;
    logic         br_mis, jp_mis;
    logic         jump_flush;

`ifdef PC_MISALIGN_TRAP_EN
    assign br_tgt = branch_target_i;
    assign jp_tgt = jump_target_i;
    assign br_mis = |branch_target_i[1:0];
    assign jp_mis = |jump_target_i[1:0];
`else
    // Without the trap, low target bits are simply dropped to keep fetch word-aligned.
    logic unused_tgt_lsbs;
    assign unused_tgt_lsbs = ^{branch_target_i[1:0], jump_target_i[1:0]};
    assign br_tgt = {branch_target_i[N-1:2], 2'b00};
    assign jp_tgt = {jump_target_i[N-1:2], 2'b00};
    assign br_mis = 1'b0;
    assign jp_mis = 1'b0;
`endif

    assign seq_pc = stall_i ? pc_value : pc_value + N'(4);
    assign state  = cur_state;

    always_comb begin
        nxt_state  = cur_state;
        nxt_cnt    = flush_cnt;
        nxt_epc    = epc;
        jump_flush = 1'b0;
        new_pc     = seq_pc;
        case (cur_state)
            BOOT: begin
                new_pc    = RESET_PC;
                nxt_state = RUN;
            end
            RUN: begin
                if (exc_i) begin
                    new_pc    = EXC_VECTOR;
                    nxt_state = EXC;
                    nxt_epc   = exc_pc_i;
                end else if (branch_taken_i && br_mis) begin
                    new_pc    = EXC_VECTOR;
                    nxt_state = EXC;
                    nxt_epc   = br_tgt;
                end else if (branch_taken_i) begin
                    new_pc    = br_tgt;
                    nxt_state = FLUSH;
                    nxt_cnt   = CNT_INIT;
                end else if (jump_i && jp_mis) begin
                    new_pc    = EXC_VECTOR;
                    nxt_state = EXC;
                    nxt_epc   = jp_tgt;
                end else if (jump_i) begin
                    new_pc     = jp_tgt;
                    jump_flush = 1'b1;
                end
            end
            FLUSH: begin
                // Wrong-path jumps and branches are dropped; exceptions still win.
                if (exc_i) begin
                    new_pc    = EXC_VECTOR;
                    nxt_state = EXC;
                    nxt_epc   = exc_pc_i;
                end else if (flush_cnt == 3'd0) begin
                    nxt_state = RUN;
                end else begin
                    nxt_cnt = flush_cnt - 3'd1;
                end
            end
            EXC: begin
                new_pc    = stall_i ? pc_value : EXC_VECTOR + N'(4);
                nxt_state = FLUSH;
                nxt_cnt   = CNT_INIT;
            end
            default: nxt_state = BOOT;
        endcase
        if (!reset) new_pc = RESET_PC;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state  <= BOOT;
            flush_cnt  <= 3'd0;
            epc        <= '0;
            flush_ifid <= 1'b0;
            flush_idex <= 1'b0;
        end else begin
            cur_state  <= nxt_state;
            flush_cnt  <= nxt_cnt;
            epc        <= nxt_epc;
            flush_idex <= (nxt_state == FLUSH);
            flush_ifid <= (nxt_state == FLUSH) || jump_flush;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= (cur_state == RUN) && !exc_i &&
                          ((branch_taken_i && br_mis) ||
                           (!branch_taken_i && jump_i && jp_mis));
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized self-checking bench for pc_sequencer against a behavioural model
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h00400000;
    localparam logic [31:0] VEC      = 32'h80000180;
    localparam int          FC       = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_value = '0;
    logic        stall_i = 1'b0;
    logic        jump_i = 1'b0;
    logic [31:0] jump_target_i = '0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        exc_i = 1'b0;
    logic [31:0] exc_pc_i = '0;
    logic [31:0] new_pc;
    logic        flush_ifid;
    logic        flush_idex;
    logic [31:0] epc;
    logic [1:0]  state;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    pc_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .pc_value        (pc_value),
        .stall_i         (stall_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .exc_i           (exc_i),
        .exc_pc_i        (exc_pc_i),
        .new_pc          (new_pc),
        .flush_ifid      (flush_ifid),
        .flush_idex      (flush_idex),
        .epc             (epc),
        .state           (state)
`ifdef PC_MISALIGN_TRAP_EN
        ,
        .misalign_o      (misalign_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: phase flags plus a count of flush cycles still owed.
    bit          m_boot, m_exc, m_jfl, m_mis;
    int          m_left;
    logic [31:0] m_epc, pc_reg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fix(input logic [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
        return t;
`else
        return {t[31:2], 2'b00};
`endif
    endfunction

    function automatic bit mis(input logic [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
        return t[1:0] != 2'b00;
`else
        return t[1:0] != t[1:0];
`endif
    endfunction

    task automatic model_reset();
        m_boot = 1'b1; m_exc = 1'b0; m_jfl = 1'b0; m_mis = 1'b0;
        m_left = 0; m_epc = '0; pc_reg = RESET_PC;
    endtask

    task automatic check_regs();
        logic [1:0] exp_state;
        bit         fl;
        exp_state = m_boot ? 2'd0 : m_exc ? 2'd3 : (m_left > 0) ? 2'd2 : 2'd1;
        fl = !m_exc && (m_left > 0);
        check("state", 32'(state), 32'(exp_state));
        check("flush_idex", 32'(flush_idex), 32'(fl));
        check("flush_ifid", 32'(flush_ifid), 32'(fl | m_jfl));
        check("epc", epc, m_epc);
`ifdef PC_MISALIGN_TRAP_EN
        check("misalign_o", 32'(misalign_o), 32'(m_mis));
`endif
    endtask

    task automatic step(input bit st, input bit jp, input logic [31:0] jt,
                        input bit br, input logic [31:0] bt,
                        input bit ex, input logic [31:0] ep,
                        input bit use_pc, input logic [31:0] pcv);
        logic [31:0] exp_pc, cap;
        bit          acc_exc, acc_br, acc_jp, trap;
        @(negedge clk);
        stall_i = st; jump_i = jp; jump_target_i = jt;
        branch_taken_i = br; branch_target_i = bt;
        exc_i = ex; exc_pc_i = ep;
        pc_value = use_pc ? pcv : pc_reg;
        acc_exc = 0; acc_br = 0; acc_jp = 0; trap = 0; cap = ep;
        if (m_boot)             exp_pc = RESET_PC;
        else if (m_exc)         exp_pc = st ? pc_value : VEC + 32'd4;
        else if (ex)            begin exp_pc = VEC; acc_exc = 1; end
        else if (m_left > 0)    exp_pc = st ? pc_value : pc_value + 32'd4;
        else if (br && mis(bt)) begin exp_pc = VEC; acc_exc = 1; trap = 1; cap = bt; end
        else if (br)            begin exp_pc = fix(bt); acc_br = 1; end
        else if (jp && mis(jt)) begin exp_pc = VEC; acc_exc = 1; trap = 1; cap = jt; end
        else if (jp)            begin exp_pc = fix(jt); acc_jp = 1; end
        else                    exp_pc = st ? pc_value : pc_value + 32'd4;
        #1 check("new_pc", new_pc, exp_pc);
        @(posedge clk);
        m_jfl = 0; m_mis = 0;
        if (m_boot)          m_boot = 0;
        else if (m_exc)      begin m_exc = 0; m_left = FC; end
        else if (acc_exc)    begin m_exc = 1; m_epc = cap; m_left = 0; m_mis = trap; end
        else if (m_left > 0) m_left--;
        else if (acc_br)     m_left = FC;
        else if (acc_jp)     m_jfl = 1;
        pc_reg = exp_pc;
        #1 check_regs();
    endtask

    task automatic idle(input bit st);
        step(st, 0, '0, 0, '0, 0, '0, 0, '0);
    endtask

    task automatic async_reset_mid_cycle();
        @(negedge clk);
        #2 reset = 1'b0;
        model_reset();
        #1;
        check("rst_new_pc", new_pc, RESET_PC);
        check_regs();
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_new_pc", new_pc, RESET_PC);
        check_regs();
        @(posedge clk);
        #1 reset = 1'b1;

        // Boot then sequential fetch
        idle(0); idle(0); idle(0);
        // Hold during stall
        step(1, 0, '0, 0, '0, 0, '0, 1, 32'h00400010);
        step(1, 0, '0, 0, '0, 0, '0, 1, 32'h00400010);
        idle(0);
        // Branch beats a simultaneous jump, then exception during the flush
        step(0, 1, 32'h00400100, 1, 32'h00400200, 0, '0, 0, '0);
        idle(0);
        step(0, 0, '0, 0, '0, 1, 32'h0040002C, 0, '0);
        idle(0); idle(0); idle(0); idle(0);
        // Address wrap
        step(0, 0, '0, 0, '0, 0, '0, 1, 32'hFFFFFFFC);
        // Misaligned jump target
        step(0, 1, 32'h00400102, 0, '0, 0, '0, 0, '0);
        idle(0); idle(0); idle(0); idle(0);
        // Reset in the middle of a flush
        step(0, 0, '0, 1, 32'h00400300, 0, '0, 0, '0);
        async_reset_mid_cycle();
        idle(0); idle(0);

        for (int i = 0; i < 400; i++) begin
            bit          st, jp, br, ex, upc;
            logic [31:0] pcv;
            st  = ($urandom % 4) == 0;
            jp  = ($urandom % 6) == 0;
            br  = ($urandom % 8) == 0;
            ex  = ($urandom % 16) == 0;
            upc = ($urandom % 10) == 0;
            pcv = ($urandom % 2) ? 32'hFFFFFFFC : $urandom;
            if (($urandom % 64) == 0) async_reset_mid_cycle();
            step(st, jp, $urandom, br, $urandom, ex, $urandom, upc, pcv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
